egress_packet_guard: RTL and testbench
======================================

// Module: egress_packet_guard
// PURPOSE
//  Shell-side receiver for an app region's TX AXI-Stream; drives a protected stream toward the network.
//  - Enforces the maximum packet length by forcing tlast and dropping the overrun.
//  - Pins tid/tdest for the whole packet to the first-beat values.
//  - Supports packet-boundary decoupling of the app region.
// PARAMETERS
//  AXIS_BUS_WIDTH     64    tdata width in bits, multiple of 8
//  AXIS_ID_WIDTH      3     tid width
//  AXIS_DEST_WIDTH    1     tdest width
//  MAX_PACKET_LENGTH  1522  max packet bytes; MAX_BEATS = ceil(MAX_PACKET_LENGTH/(AXIS_BUS_WIDTH/8)) = 191 at defaults
//  CNT_WIDTH          32    status counter width
// PORTS
//  aclk               in   1          clock; all signals synchronous
//  areset             in   1          synchronous active-high reset
//  axis_in_tdata      in   BUS        app TX data
//  axis_in_tid        in   ID         app TX id
//  axis_in_tdest      in   DEST       app TX dest
//  axis_in_tkeep      in   BUS/8      app TX byte enables
//  axis_in_tlast      in   1          app TX end of packet
//  axis_in_tvalid     in   1          app TX valid
//  axis_in_tready     out  1          app TX ready
//  axis_out_t*        out  as above   protected stream (tdata,tid,tdest,tkeep,tlast,tvalid)
//  axis_out_tready    in   1          downstream ready
//  decouple_req       in   1          request to isolate the app at the next packet boundary
//  decouple_ack       out  1          app isolated and output drained
//  forced_tlast_cnt   out  CNT_WIDTH  packets truncated (saturating)
//  dropped_beat_cnt   out  CNT_WIDTH  input beats discarded (saturating)
// BEHAVIOUR
//  Reset
//  - state=FIRST, beat_cnt=0, skid buffer empty, both counters=0.
//  - axis_in_tready=0, axis_out_tvalid=0, decouple_ack=0 during reset and the first cycle after.
//  - Reset asserted mid-packet discards all in-flight beats with no tlast emitted; the next accepted beat is a first beat.
//  Latency and handshake
//  - 1 cycle from input accept to axis_out_tvalid, via a 2-entry skid buffer: full throughput, no combinational ready path.
//  - axis_in_tready is independent of axis_in_tvalid. Output beats obey AXI-S: valid/payload held stable until tready.
//  FSM states
//  - FIRST
//    - decouple_req=1 -> DECOUPLED, no beat accepted that cycle.
//    - Else on accept: latch tid/tdest, forward the beat, beat_cnt=1.
//    - Then: stay in FIRST if tlast=1; MID otherwise (MAX_BEATS>=2 assumed).
//  - MID: forward beats with the latched tid/tdest; beat_cnt++.
//    - tlast=1 -> FIRST.
//    - Accepted beat is beat number MAX_BEATS with tlast=0: forward it with tlast forced to 1, tkeep unchanged; forced_tlast_cnt++; -> DROP.
//    - Natural tlast exactly at MAX_BEATS: forwarded, not counted as forced.
//  - DROP: axis_in_tready=1; beats discarded, not forwarded; dropped_beat_cnt++ per beat; on tlast -> FIRST.
//  - DECOUPLED: axis_in_tready=0.
//    - decouple_ack=1 once the skid buffer is empty.
//    - decouple_req=0 -> FIRST, ack drops the same cycle.
//  - decouple_req raised in MID/DROP is honoured only after the packet's tlast is accepted; never splits a packet.
//  Counters
//  - Saturate at all-ones; no wrap.
//  - A truncation and a drop in the same cycle cannot occur (different states).
// STRUCTURE
//  - Package egress_guard_pkg: state_e enum {FIRST,MID,DROP,DECOUPLED}; function max_beats(len,bus_width).
//  - Sub-module axis_skid_buffer #(DATA_WIDTH): 2-entry, aclk/areset, in/out valid/ready/data.
//    Payload packing {tdata,tid,tdest,tkeep,tlast}.
// TESTING
//  1. 3-beat packet, tid=5, tdest=1, out_tready=1 -> identical 3 beats out, each 1 cycle after accept; counters 0.
//  2. tid changes 5->2 on beat 2 -> all output beats carry tid=5.
//  3. 200-beat packet, no tlast until beat 200 -> beat 191 out with tlast=1; 9 beats dropped; forced_tlast_cnt=1; dropped_beat_cnt=9.
//  4. Exactly 191 beats, tlast on 191 -> forwarded intact; forced_tlast_cnt=0.
//  5. decouple_req raised at beat 2 of a 4-beat packet, out_tready toggling 1010 -> all 4 beats out; in_tready=0 after; ack once drained.
//  6. areset pulse at beat 3 of 5 -> out_tvalid=0 next cycle; counters 0; next packet's tid latched fresh.

Source files
------------

// File: rtl/egress_guard_pkg.sv
// Shared types and helpers for the egress packet guard.
// Holds the packet-tracking state enum and the beat-limit arithmetic.
package egress_guard_pkg;

    typedef enum logic [1:0] {
        FIRST,
        MID,
        DROP,
        DECOUPLED
    } state_e;

    // Number of bus beats needed to carry len bytes, rounded up.
    function automatic int max_beats(input int len, input int bus_width);
        return (len + bus_width / 8 - 1) / (bus_width / 8);
    endfunction

endpackage

// File: rtl/egress_packet_guard_skid.sv
// Two-entry AXI-Stream skid buffer: one cycle of latency, full throughput,
// and an upstream ready that depends only on local registers.
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  run_reg;
    logic                  out_valid_reg;
    logic                  skid_valid_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [DATA_WIDTH-1:0] skid_data_reg;
    logic                  in_fire;
    logic                  load_out;
    logic                  load_skid;
    logic                  unload_skid;

    // Ready only looks at the skid slot, so downstream ready never reaches upstream.
    assign in_ready    = run_reg & ~skid_valid_reg;
    assign in_fire     = in_valid & in_ready;
    assign unload_skid = skid_valid_reg & out_ready;
    assign load_out    = in_fire & (~out_valid_reg | out_ready);
    assign load_skid   = in_fire & out_valid_reg & ~out_ready;

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

    always_ff @(posedge aclk) begin
        if (areset) begin
            run_reg        <= 1'b0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (load_out || unload_skid) begin
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (load_skid) begin
                skid_valid_reg <= 1'b1;
            end else if (unload_skid) begin
                skid_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (unload_skid) begin
            out_data_reg <= skid_data_reg;
        end else if (load_out) begin
            out_data_reg <= in_data;
        end
        if (load_skid) begin
            skid_data_reg <= in_data;
        end
    end

endmodule

// File: rtl/egress_packet_guard.sv
// Protects the network-facing TX stream from an app region: caps packet length,
// pins tid/tdest per packet and isolates the app on packet boundaries.
module egress_packet_guard
    import egress_guard_pkg::*;
#(
    parameter int AXIS_BUS_WIDTH    = 64,
    parameter int AXIS_ID_WIDTH     = 3,
    parameter int AXIS_DEST_WIDTH   = 1,
    parameter int MAX_PACKET_LENGTH = 1522,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [AXIS_BUS_WIDTH-1:0]    axis_in_tdata,
    input  logic [AXIS_ID_WIDTH-1:0]     axis_in_tid,
    input  logic [AXIS_DEST_WIDTH-1:0]   axis_in_tdest,
    input  logic [AXIS_BUS_WIDTH/8-1:0]  axis_in_tkeep,
    input  logic                         axis_in_tlast,
    input  logic                         axis_in_tvalid,
    output logic                         axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]    axis_out_tdata,
    output logic [AXIS_ID_WIDTH-1:0]     axis_out_tid,
    output logic [AXIS_DEST_WIDTH-1:0]   axis_out_tdest,
    output logic [AXIS_BUS_WIDTH/8-1:0]  axis_out_tkeep,
    output logic                         axis_out_tlast,
    output logic                         axis_out_tvalid,
    input  logic                         axis_out_tready,
    input  logic                         decouple_req,
    output logic                         decouple_ack,
    output logic [CNT_WIDTH-1:0]         forced_tlast_cnt,
    output logic [CNT_WIDTH-1:0]         dropped_beat_cnt
);

    localparam int MAX_BEATS     = max_beats(MAX_PACKET_LENGTH, AXIS_BUS_WIDTH);
    localparam int KEEP_WIDTH    = AXIS_BUS_WIDTH / 8;
    localparam int BEAT_WIDTH    = $clog2(MAX_BEATS + 1);
    localparam int PAYLOAD_WIDTH = AXIS_BUS_WIDTH + AXIS_ID_WIDTH + AXIS_DEST_WIDTH + KEEP_WIDTH + 1;

    state_e                       state_reg;
    logic [BEAT_WIDTH-1:0]        beat_cnt_reg;
    logic [AXIS_ID_WIDTH-1:0]     tid_reg;
    logic [AXIS_DEST_WIDTH-1:0]   tdest_reg;
    logic [CNT_WIDTH-1:0]         forced_cnt_reg;
    logic [CNT_WIDTH-1:0]         dropped_cnt_reg;

    logic                         accept;
    logic [BEAT_WIDTH-1:0]        beat_next;
    logic                         at_limit;
    logic [AXIS_ID_WIDTH-1:0]     fwd_tid;
    logic [AXIS_DEST_WIDTH-1:0]   fwd_tdest;
    logic                         fwd_tlast;
    logic                         skid_in_valid;
    logic                         skid_in_ready;
    logic                         skid_out_valid;
    logic [PAYLOAD_WIDTH-1:0]     skid_in_data;
    logic [PAYLOAD_WIDTH-1:0]     skid_out_data;

    // Decouple in FIRST blocks the beat of that same cycle so no packet starts.
    always_comb begin
        axis_in_tready = 1'b0;
        if (!areset) begin
            case (state_reg)
                FIRST:   axis_in_tready = skid_in_ready & ~decouple_req;
                MID:     axis_in_tready = skid_in_ready;
                DROP:    axis_in_tready = 1'b1;
                default: axis_in_tready = 1'b0;
            endcase
        end
    end

    assign accept    = axis_in_tvalid & axis_in_tready;
    assign beat_next = (state_reg == FIRST) ? BEAT_WIDTH'(1) : beat_cnt_reg + BEAT_WIDTH'(1);
    assign at_limit  = (state_reg == MID) && (beat_next == BEAT_WIDTH'(MAX_BEATS)) && !axis_in_tlast;
    assign fwd_tid   = (state_reg == FIRST) ? axis_in_tid : tid_reg;
    assign fwd_tdest = (state_reg == FIRST) ? axis_in_tdest : tdest_reg;
    assign fwd_tlast = axis_in_tlast | at_limit;

    assign skid_in_valid = accept & (state_reg != DROP);
    assign skid_in_data  = {axis_in_tdata, fwd_tid, fwd_tdest, axis_in_tkeep, fwd_tlast};

    axis_skid_buffer #(
        .DATA_WIDTH(PAYLOAD_WIDTH)
    ) u_skid (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .in_data   (skid_in_data),
        .out_valid (skid_out_valid),
        .out_ready (axis_out_tready),
        .out_data  (skid_out_data)
    );

    assign {axis_out_tdata, axis_out_tid, axis_out_tdest, axis_out_tkeep, axis_out_tlast} = skid_out_data;
    assign axis_out_tvalid  = skid_out_valid;
    assign decouple_ack     = (state_reg == DECOUPLED) & ~skid_out_valid;
    assign forced_tlast_cnt = forced_cnt_reg;
    assign dropped_beat_cnt = dropped_cnt_reg;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg       <= FIRST;
            beat_cnt_reg    <= '0;
            tid_reg         <= '0;
            tdest_reg       <= '0;
            forced_cnt_reg  <= '0;
            dropped_cnt_reg <= '0;
        end else begin
            case (state_reg)
                FIRST: begin
                    if (decouple_req) begin
                        state_reg <= DECOUPLED;
                    end else if (accept) begin
                        tid_reg      <= axis_in_tid;
                        tdest_reg    <= axis_in_tdest;
                        beat_cnt_reg <= beat_next;
                        if (!axis_in_tlast) begin
                            state_reg <= MID;
                        end
                    end
                end
                MID: begin
                    if (accept) begin
                        beat_cnt_reg <= beat_next;
                        if (axis_in_tlast) begin
                            state_reg <= FIRST;
                        end else if (at_limit) begin
                            state_reg <= DROP;
                            if (forced_cnt_reg != '1) begin
                                forced_cnt_reg <= forced_cnt_reg + CNT_WIDTH'(1);
                            end
                        end
                    end
                end
                DROP: begin
                    if (accept) begin
                        if (dropped_cnt_reg != '1) begin
                            dropped_cnt_reg <= dropped_cnt_reg + CNT_WIDTH'(1);
                        end
                        if (axis_in_tlast) begin
                            state_reg <= FIRST;
                        end
                    end
                end
                default: begin
                    if (!decouple_req) begin
                        state_reg <= FIRST;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_egress_packet_guard.sv
// Randomised self-checking bench for egress_packet_guard against a packet-level
// reference model (truncate to the beat limit, pin first-beat tid/tdest).
`timescale 1ns/1ps
module tb_egress_packet_guard;

    localparam int BW   = 64;
    localparam int IW   = 3;
    localparam int DW   = 1;
    localparam int KW   = BW / 8;
    localparam int CW   = 32;
    localparam int MAXB = (1522 + KW - 1) / KW;  // 191 beats

    typedef struct packed {
        logic [BW-1:0] data;
        logic [IW-1:0] id;
        logic [DW-1:0] dest;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic [BW-1:0] axis_in_tdata;
    logic [IW-1:0] axis_in_tid;
    logic [DW-1:0] axis_in_tdest;
    logic [KW-1:0] axis_in_tkeep;
    logic          axis_in_tlast;
    logic          axis_in_tvalid;
    logic          axis_in_tready;
    logic [BW-1:0] axis_out_tdata;
    logic [IW-1:0] axis_out_tid;
    logic [DW-1:0] axis_out_tdest;
    logic [KW-1:0] axis_out_tkeep;
    logic          axis_out_tlast;
    logic          axis_out_tvalid;
    logic          axis_out_tready;
    logic          decouple_req;
    logic          decouple_ack;
    logic [CW-1:0] forced_tlast_cnt;
    logic [CW-1:0] dropped_beat_cnt;

    always #5 aclk = ~aclk;

    egress_packet_guard #(
        .AXIS_BUS_WIDTH(BW), .AXIS_ID_WIDTH(IW), .AXIS_DEST_WIDTH(DW),
        .MAX_PACKET_LENGTH(1522), .CNT_WIDTH(CW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .axis_in_tdata(axis_in_tdata), .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
        .axis_in_tkeep(axis_in_tkeep), .axis_in_tlast(axis_in_tlast),
        .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
        .axis_out_tdata(axis_out_tdata), .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest),
        .axis_out_tkeep(axis_out_tkeep), .axis_out_tlast(axis_out_tlast),
        .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
        .decouple_req(decouple_req), .decouple_ack(decouple_ack),
        .forced_tlast_cnt(forced_tlast_cnt), .dropped_beat_cnt(dropped_beat_cnt)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    stab_err = 0;
    int    exp_forced = 0;
    int    exp_dropped = 0;
    bit    toggle_ready = 0;
    bit    rand_ready = 0;
    bit    prev_stall = 0;
    beat_t prev_out;
    beat_t cur_out;
    beat_t pkt_q[$];
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    obs_cyc_q[$];
    int    acc_cyc_q[$];

    assign cur_out = {axis_out_tdata, axis_out_tid, axis_out_tdest, axis_out_tkeep, axis_out_tlast};

    always @(posedge aclk) cyc <= cyc + 1;

    // Observe handshakes on the falling edge; they complete at the next rising edge.
    always @(negedge aclk) begin
        if (areset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!axis_out_tvalid || cur_out != prev_out)) stab_err <= stab_err + 1;
            prev_stall <= axis_out_tvalid && !axis_out_tready;
            prev_out   <= cur_out;
            if (axis_out_tvalid && axis_out_tready) begin
                obs_q.push_back(cur_out);
                obs_cyc_q.push_back(cyc);
            end
            if (axis_in_tvalid && axis_in_tready) acc_cyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
        if (toggle_ready) axis_out_tready = ~axis_out_tready;
        else if (rand_ready) axis_out_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic make_packet(input int len, input logic [IW-1:0] id, input logic [DW-1:0] dest,
                               input int chg_at, input logic [IW-1:0] id2);
        beat_t b;
        pkt_q.delete();
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = (i == len - 1) ? KW'($urandom_range(1, 255)) : '1;
            b.id   = (chg_at >= 0 && i >= chg_at) ? id2 : id;
            b.dest = (chg_at >= 0 && i >= chg_at) ? ~dest : dest;
            b.last = (i == len - 1);
            pkt_q.push_back(b);
        end
    endtask

    // Reference: keep at most MAXB beats, first-beat tid/tdest, tlast on the last kept beat.
    function automatic void model_packet();
        int    n = pkt_q.size();
        int    kept = (n > MAXB) ? MAXB : n;
        beat_t b;
        for (int i = 0; i < kept; i++) begin
            b      = pkt_q[i];
            b.id   = pkt_q[0].id;
            b.dest = pkt_q[0].dest;
            b.last = (i == kept - 1);
            exp_q.push_back(b);
        end
        if (n > MAXB) begin
            exp_forced  = exp_forced + 1;
            exp_dropped = exp_dropped + (n - MAXB);
        end
    endfunction

    task automatic drive_packet(input int nbeats, input int gap_pct, input int dec_at, output bit ok);
        bit hs;
        ok = 1;
        for (int i = 0; i < nbeats && ok; i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                axis_in_tvalid = 1'b0;
                tick();
            end
            if (i == dec_at) decouple_req = 1'b1;
            {axis_in_tdata, axis_in_tid, axis_in_tdest, axis_in_tkeep, axis_in_tlast} = pkt_q[i];
            axis_in_tvalid = 1'b1;
            for (int t = 0; ; t++) begin
                hs = axis_in_tready;
                tick();
                if (hs) break;
                if (t >= 1000) begin ok = 0; break; end
            end
        end
        axis_in_tvalid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 0;
        for (int t = 0; t < 1000; t++) begin
            if (obs_q.size() >= exp_q.size() && !axis_out_tvalid) begin ok = 1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (axis_in_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b expected 0", axis_in_tready); end
        checks++; if (axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", axis_out_tvalid); end
        checks++; if (forced_tlast_cnt !== '0 || dropped_beat_cnt !== '0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", forced_tlast_cnt, dropped_beat_cnt); end
        areset = 1'b0;
        checks++; if (axis_in_tready !== 1'b0 || decouple_ack !== 1'b0) begin errors++; $display("FAIL rst_first_cycle: got tready=%b ack=%b expected 0/0", axis_in_tready, decouple_ack); end
        tick();
        checks++; if (axis_in_tready !== 1'b1) begin errors++; $display("FAIL rst_release: got tready=%b expected 1", axis_in_tready); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        bit ok;
        clear_sb();
        make_packet(3, 3'd5, 1'b1, -1, 3'd0);
        model_packet();
        drive_packet(3, 0, -1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_drive: got timeout expected accept"); end
        wait_drain(ok);
        checks++; if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        foreach (acc_cyc_q[i]) if (i < obs_cyc_q.size()) begin
            checks++; if (obs_cyc_q[i] != acc_cyc_q[i] + 1) begin errors++; $display("FAIL basic_latency%0d: got %0d cycles expected 1", i, obs_cyc_q[i] - acc_cyc_q[i]); end
        end
        checks++; if (forced_tlast_cnt !== CW'(exp_forced) || dropped_beat_cnt !== CW'(exp_dropped)) begin errors++; $display("FAIL basic_cnt: got %0d/%0d expected %0d/%0d", forced_tlast_cnt, dropped_beat_cnt, exp_forced, exp_dropped); end
        $display("test_basic: %0d beats out", obs_q.size());
    endtask

    task automatic test_tid_pin();
        bit ok;
        clear_sb();
        make_packet(4, 3'd5, 1'b1, 1, 3'd2);
        model_packet();
        drive_packet(4, 30, -1, ok);
        wait_drain(ok);
        checks++; if (!ok || obs_q.size() != 4) begin errors++; $display("FAIL pin_count: got %0d beats expected 4", obs_q.size()); end
        foreach (obs_q[i]) begin
            checks++; if (obs_q[i].id !== 3'd5 || obs_q[i].dest !== 1'b1) begin errors++; $display("FAIL pin_beat%0d: got tid=%0d tdest=%0d expected 5/1", i, obs_q[i].id, obs_q[i].dest); end
            if (i < exp_q.size()) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL pin_payload%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
            end
        end
        $display("test_tid_pin: %0d beats out", obs_q.size());
    endtask

    task automatic test_truncate(input int len);
        bit ok;
        clear_sb();
        make_packet(len, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, 3'd0);
        model_packet();
        drive_packet(len, 10, -1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL len%0d_drive: got timeout expected accept", len); end
        wait_drain(ok);
        checks++; if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL len%0d_count: got %0d beats expected %0d", len, obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL len%0d_beat%0d: got %h expected %h", len, i, obs_q[i], exp_q[i]); end
        end
        checks++; if (forced_tlast_cnt !== CW'(exp_forced)) begin errors++; $display("FAIL len%0d_forced: got %0d expected %0d", len, forced_tlast_cnt, exp_forced); end
        checks++; if (dropped_beat_cnt !== CW'(exp_dropped)) begin errors++; $display("FAIL len%0d_dropped: got %0d expected %0d", len, dropped_beat_cnt, exp_dropped); end
        $display("test_truncate len=%0d: %0d beats out, forced=%0d dropped=%0d", len, obs_q.size(), forced_tlast_cnt, dropped_beat_cnt);
    endtask

    task automatic test_decouple();
        bit ok;
        int seen;
        clear_sb();
        toggle_ready = 1;
        make_packet(4, 3'd4, 1'b0, -1, 3'd0);
        model_packet();
        drive_packet(4, 0, 1, ok);
        repeat (2) tick();
        checks++; if (axis_in_tready !== 1'b0) begin errors++; $display("FAIL dec_tready: got %b expected 0", axis_in_tready); end
        // A beat offered while decoupled must never be taken.
        {axis_in_tdata, axis_in_tid, axis_in_tdest, axis_in_tkeep, axis_in_tlast} = pkt_q[0];
        axis_in_tvalid = 1'b1;
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            if (decouple_ack) seen = 1; else tick();
        end
        checks++; if (!seen || axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL dec_ack: got ack=%0d tvalid=%b expected 1/0", seen, axis_out_tvalid); end
        checks++; if (obs_q.size() != 4 || acc_cyc_q.size() != 4) begin errors++; $display("FAIL dec_count: got %0d out/%0d in expected 4/4", obs_q.size(), acc_cyc_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL dec_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        axis_in_tvalid = 1'b0;
        toggle_ready = 0;
        axis_out_tready = 1'b1;
        decouple_req = 1'b0;
        tick();
        checks++; if (decouple_ack !== 1'b0 || axis_in_tready !== 1'b1) begin errors++; $display("FAIL dec_release: got ack=%b tready=%b expected 0/1", decouple_ack, axis_in_tready); end
        $display("test_decouple: %0d beats out", obs_q.size());
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_sb();
        axis_out_tready = 1'b0;
        make_packet(5, 3'd3, 1'b1, -1, 3'd0);
        drive_packet(2, 0, -1, ok);
        {axis_in_tdata, axis_in_tid, axis_in_tdest, axis_in_tkeep, axis_in_tlast} = pkt_q[2];
        axis_in_tvalid = 1'b1;
        areset = 1'b1;
        tick();
        axis_in_tvalid = 1'b0;
        checks++; if (axis_out_tvalid !== 1'b0 || axis_in_tready !== 1'b0) begin errors++; $display("FAIL rmid_valid: got tvalid=%b tready=%b expected 0/0", axis_out_tvalid, axis_in_tready); end
        checks++; if (forced_tlast_cnt !== '0 || dropped_beat_cnt !== '0) begin errors++; $display("FAIL rmid_cnt: got %0d/%0d expected 0/0", forced_tlast_cnt, dropped_beat_cnt); end
        areset = 1'b0;
        axis_out_tready = 1'b1;
        tick();
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rmid_flush: got %0d beats out expected 0", obs_q.size()); end
        clear_sb();
        exp_forced = 0;
        exp_dropped = 0;
        make_packet(3, 3'd6, 1'b0, -1, 3'd0);
        model_packet();
        drive_packet(3, 0, -1, ok);
        wait_drain(ok);
        checks++; if (!ok || obs_q.size() != 3) begin errors++; $display("FAIL rmid_count: got %0d beats expected 3", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        $display("test_reset_mid: %0d beats after reset, tid=%0d", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].id : 0);
    endtask

    task automatic test_random();
        bit ok;
        bit all_ok = 1;
        int len;
        clear_sb();
        rand_ready = 1;
        for (int p = 0; p < 20; p++) begin
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(MAXB - 5, MAXB + 8) : $urandom_range(1, 12);
            make_packet(len, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 1) != 0) ? $urandom_range(1, 4) : -1, 3'($urandom_range(0, 7)));
            model_packet();
            drive_packet(len, 25, -1, ok);
            all_ok = all_ok & ok;
        end
        rand_ready = 0;
        axis_out_tready = 1'b1;
        wait_drain(ok);
        checks++; if (!all_ok || !ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (forced_tlast_cnt !== CW'(exp_forced) || dropped_beat_cnt !== CW'(exp_dropped)) begin errors++; $display("FAIL rnd_cnt: got %0d/%0d expected %0d/%0d", forced_tlast_cnt, dropped_beat_cnt, exp_forced, exp_dropped); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL rnd_stall_stability: got %0d violations expected 0", stab_err); end
        $display("test_random: %0d beats out, forced=%0d dropped=%0d", obs_q.size(), forced_tlast_cnt, dropped_beat_cnt);
    endtask

    initial begin
        areset          = 1'b1;
        axis_in_tdata   = '0;
        axis_in_tid     = '0;
        axis_in_tdest   = '0;
        axis_in_tkeep   = '0;
        axis_in_tlast   = 1'b0;
        axis_in_tvalid  = 1'b0;
        axis_out_tready = 1'b1;
        decouple_req    = 1'b0;
        test_reset();
        test_basic();
        test_tid_pin();
        test_truncate(200);
        test_truncate(MAXB);
        test_decouple();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
